// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: data width, bubble encoding,
// fetch FSM states and the IF/ID pipeline record.
package cpu_pkg;

  localparam int XLEN = 32;

  // Instruction placed in IF/ID whenever the stage inserts a bubble.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-side bus: the instruction memory port plus the IF/ID register
// contents handed to decode. The fetch stage is the master.
interface instruction_fetch_stage_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic [XLEN-1:0] if_id_instr;
  logic            if_id_valid;

  modport master (
    output imem_addr,
    input  imem_instr,
    output if_id_pc,
    output if_id_pc_plus4,
    output if_id_instr,
    output if_id_valid
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  if_id_pc,
    input  if_id_pc_plus4,
    input  if_id_instr,
    input  if_id_valid
  );

endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register. Bubble has priority over load; a bubble
// clears valid and forces the NOP encoding but keeps the PC fields so
// decode still sees the last real PC pair.
module if_id_register
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_r;

  // Register update: reset, bubble, load or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r.pc       <= 32'h0000_0000;
      q_r.pc_plus4 <= 32'h0000_0000;
      q_r.instr    <= NOP_INSTR;
      q_r.valid    <= 1'b0;
    end else if (bubble) begin
      q_r.valid    <= 1'b0;
      q_r.instr    <= NOP_INSTR;
    end else if (load) begin
      q_r          <= d;
    end else begin
      q_r          <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the zero-latency
// instruction memory and fills the IF/ID register. Misaligned redirects
// and fetches past the end of memory park the stage in a sticky FAULT
// state that only reset leaves.
module instruction_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          IMEM_DEPTH_WORDS = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall_f,
  input  logic                        flush_d,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  instruction_fetch_stage_if.master   bus,
  output logic                        fetch_fault,
  output logic [XLEN-1:0]             fetch_count
);

  localparam logic [XLEN-1:0] DEPTH_WORDS = XLEN'(IMEM_DEPTH_WORDS);

  fetch_state_e    state_r;
  fetch_state_e    state_next_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic            in_range_s;
  logic            ifid_load_s;
  logic            ifid_bubble_s;
  logic            count_inc_s;
  logic            fetch_fault_r;
  logic [XLEN-1:0] fetch_count_r;
  if_id_t          ifid_d_s;
  if_id_t          ifid_q_s;

  assign pc_plus4_s = pc_r + 32'd4;
  // The range check looks at the same PC that is being fetched, so an
  // out-of-range word is never captured, including after PC wrap.
  assign in_range_s = ({2'b00, pc_r[XLEN-1:2]} < DEPTH_WORDS);

  assign ifid_d_s.pc       = pc_r;
  assign ifid_d_s.pc_plus4 = pc_plus4_s;
  assign ifid_d_s.instr    = bus.imem_instr;
  assign ifid_d_s.valid    = 1'b1;

  // Next-state, next-PC and IF/ID control in priority order.
  always_comb begin
    state_next_s  = state_r;
    pc_next_s     = pc_r;
    ifid_load_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    count_inc_s   = 1'b0;
    case (state_r)
      RUN: begin
        if (redirect_valid) begin
          ifid_bubble_s = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            state_next_s = FAULT;
          end else begin
            pc_next_s = redirect_pc;
          end
        end else if (stall_f) begin
          if (flush_d) begin
            ifid_bubble_s = 1'b1;
          end else begin
            ifid_bubble_s = 1'b0;
          end
        end else if (!in_range_s) begin
          state_next_s  = FAULT;
          ifid_bubble_s = 1'b1;
        end else begin
          pc_next_s = pc_plus4_s;
          if (flush_d) begin
            ifid_bubble_s = 1'b1;
          end else begin
            ifid_load_s = 1'b1;
            count_inc_s = 1'b1;
          end
        end
      end
      FAULT: begin
        ifid_bubble_s = 1'b1;
      end
      default: begin
        state_next_s  = FAULT;
        ifid_bubble_s = 1'b1;
      end
    endcase
  end

  // State, PC, sticky fault flag and fetch counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RUN;
      pc_r          <= RESET_PC;
      fetch_fault_r <= 1'b0;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      state_r       <= state_next_s;
      pc_r          <= pc_next_s;
      fetch_fault_r <= (state_next_s == FAULT);
      if (count_inc_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
    end
  end

  if_id_register u_if_id (
    .clk    (clk),
    .reset  (reset),
    .load   (ifid_load_s),
    .bubble (ifid_bubble_s),
    .d      (ifid_d_s),
    .q      (ifid_q_s)
  );

  assign bus.imem_addr      = pc_r;
  assign bus.if_id_pc       = ifid_q_s.pc;
  assign bus.if_id_pc_plus4 = ifid_q_s.pc_plus4;
  assign bus.if_id_instr    = ifid_q_s.instr;
  assign bus.if_id_valid    = ifid_q_s.valid;
  assign fetch_fault        = fetch_fault_r;
  assign fetch_count        = fetch_count_r;

endmodule
